// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that times the PC/IR/regfile/dmem enables.
// Optional perf counters (retired_cnt, stall_cnt) are built when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       cond_true,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       reg_write_en,
  output logic       busy,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_fault,
  output logic [2:0] state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LDR, C_LDA, C_STR, C_JMP, C_JCC, C_ILL
  } cls_e;

  localparam int WCW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'(WAIT_MAX);

  function automatic cls_e classify(input logic [5:0] op);
    cls_e c;
    case (op) inside
      6'd0:                                              c = C_NOP;
      [6'd1:6'd4], [6'd9:6'd12], 6'd14, [6'd17:6'd20],
      6'd25, 6'd26:                                      c = C_ALU;
      6'd41:                                             c = C_LDR;
      6'd42:                                             c = C_LDA;
      6'd43:                                             c = C_STR;
      6'd56:                                             c = C_JMP;
      [6'd57:6'd62]:                                     c = C_JCC;
      default:                                           c = C_ILL;
    endcase
    return c;
  endfunction

  state_e         state_q, state_d;
  cls_e           cls_q, cls_in;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           illegal_q, fault_q;
  logic           bnd, ill_set, flt_set, stall, timeout;

  assign cls_in  = classify(opcode);
  assign stall   = (state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready);
  assign timeout = (WAIT_MAX > 0) && (state_q == S_FETCH || state_q == S_MEM) && (wcnt_q == WLIM);

  always_comb begin
    state_d = state_q;
    bnd     = 1'b0;
    ill_set = 1'b0;
    flt_set = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (timeout) begin
          state_d = S_HALT;
          flt_set = 1'b1;
        end else if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cls_in)
          C_NOP:   bnd = 1'b1;
          C_ILL: begin
            state_d = S_HALT;
            ill_set = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_ALU, C_LDA: state_d = S_WB;
          C_LDR, C_STR: state_d = S_MEM;
          default:      bnd = 1'b1;
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          state_d = S_HALT;
          flt_set = 1'b1;
        end else if (dmem_ready) begin
          if (cls_q == C_LDR) state_d = S_WB;
          else                bnd = 1'b1;
        end
      end
      S_WB:     bnd = 1'b1;
      default:  state_d = S_HALT;
    endcase
    if (bnd) state_d = run ? S_FETCH : S_IDLE;
  end

  // Wait counter only runs while stalled in the same state; any move or ready clears it.
  always_comb begin
    wcnt_d = '0;
    if (stall && state_d == state_q && wcnt_q != WLIM) wcnt_d = wcnt_q + WCW'(1);
    else if (stall && state_d == state_q)               wcnt_d = wcnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NOP;
      wcnt_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == S_DECODE) cls_q <= cls_in;
      if (ill_set) illegal_q <= 1'b1;
      if (flt_set) fault_q   <= 1'b1;
    end
  end

  // Strobes decode the registered state; ir_write/pc_load also follow same-cycle inputs.
  assign imem_req     = (state_q == S_FETCH);
  assign ir_write     = (state_q == S_FETCH) && imem_ready && !timeout;
  assign pc_inc       = ir_write;
  assign dmem_req     = (state_q == S_MEM);
  assign dmem_we      = (state_q == S_MEM) && (cls_q == C_STR);
  assign pc_load      = (state_q == S_EXEC) && ((cls_q == C_JMP) || (cls_q == C_JCC && cond_true));
  assign reg_write_en = (state_q == S_WB);
  assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted       = (state_q == S_HALT);
  assign illegal_op   = illegal_q;
  assign bus_fault    = fault_q;
  assign state        = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (bnd && retired_q != {CNT_W{1'b1}}) retired_q <= retired_q + 1'b1;
      if (stall && stall_q != {CNT_W{1'b1}}) stall_q   <= stall_q + 1'b1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
